// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan logic.
// Segment patterns are active-low: bit 7 = dp, bits 6:0 = g..a.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hc0;
    localparam logic [7:0] SEG_1     = 8'hf9;
    localparam logic [7:0] SEG_2     = 8'ha4;
    localparam logic [7:0] SEG_3     = 8'hb0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hf8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hbf;
    localparam logic [7:0] SEG_BLANK = 8'hff;

    // Per-digit select level for a dark digit; replicate to the digit count.
    localparam logic DIG_OFF = 1'b1;

endpackage

// File: rtl/seg_decoder.sv
// Combinational digit code + decimal point to active-low segment pattern.
// Codes 10..14 show a dash, 15 is blank.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            4'd15:   seg_o = SEG_BLANK;
            default: seg_o = SEG_DASH;
        endcase
        if (dp_i) begin
            seg_o[7] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a multiplexed 7-segment display: time-slices the digits,
// double-buffers updates at frame boundaries, blanks leading zeros, dims by on-time.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [2:0]              brightness,
    output logic                    frame_tick,
    output logic [NUM_DIGITS-1:0]   DIG,
    output logic [7:0]              Y
);

    localparam int TW   = $clog2(TICKS_PER_DIGIT);
    localparam int SW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int STEP = TICKS_PER_DIGIT / 8;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

    logic [TW-1:0]           tick_q, tick_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [4*NUM_DIGITS-1:0] act_bcd_q, act_bcd_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [2:0]              bri_q, bri_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic [7:0]              y_q, y_d;

    logic                    tick_last;
    logic                    frame_end;
    logic                    xfer;
    logic [31:0]             on_time;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   zero_up;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_lz;
    logic [7:0]              dec_seg;

    assign tick_last = (tick_q == TICK_LAST);
    assign frame_end = tick_last && (slot_q == SLOT_LAST);
    assign xfer      = upd_valid && !pend_valid_q;

    // Slot tick 0 stays dark so the previous digit's segments never ghost onto the next.
    assign on_time = (32'(bri_q) + 32'd1) * 32'(STEP);
    assign lit     = (tick_q != '0) && (32'(tick_q) < on_time);

    // zero_up[i]: active digits i..N-1 are all zero.
    always_comb begin
        zero_up = '0;
        zero_up[NUM_DIGITS-1] = (act_bcd_q[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_up[i] = (act_bcd_q[4*i +: 4] == 4'd0) && zero_up[i+1];
        end
    end

    always_comb begin
        cur_code = 4'd0;
        cur_dp   = 1'b0;
        cur_lz   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SW'(i)) begin
                cur_code = act_bcd_q[4*i +: 4];
                cur_dp   = act_dp_q[i];
                cur_lz   = blank_lz && zero_up[i] && (i != 0);
            end
        end
    end

    seg_decoder u_dec (
        .code_i (cur_code),
        .dp_i   (cur_dp),
        .seg_o  (dec_seg)
    );

    always_comb begin
        tick_d       = tick_last ? '0 : tick_q + 1'b1;
        slot_d       = slot_q;
        act_bcd_d    = act_bcd_q;
        act_dp_d     = act_dp_q;
        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        bri_d        = bri_q;
        frame_tick_d = frame_end;
        dig_d        = {NUM_DIGITS{DIG_OFF}};
        y_d          = SEG_BLANK;

        if (tick_last) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end
        if (tick_q == '0) begin
            bri_d = brightness;
        end

        // A capture can only happen with the shadow empty, so it never races a promotion.
        if (xfer) begin
            pend_bcd_d   = bcd_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end else if (frame_end && pend_valid_q) begin
            act_bcd_d    = pend_bcd_q;
            act_dp_d     = pend_dp_q;
            pend_valid_d = 1'b0;
        end

        if (lit) begin
            y_d = dec_seg;
            if (cur_lz) begin
                y_d[6:0] = 7'h7f;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (slot_q == SW'(i)) begin
                    dig_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q       <= '0;
            slot_q       <= '0;
            act_bcd_q    <= '0;
            act_dp_q     <= '0;
            pend_bcd_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            bri_q        <= '0;
            frame_tick_q <= 1'b0;
            dig_q        <= {NUM_DIGITS{DIG_OFF}};
            y_q          <= SEG_BLANK;
        end else begin
            tick_q       <= tick_d;
            slot_q       <= slot_d;
            act_bcd_q    <= act_bcd_d;
            act_dp_q     <= act_dp_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            bri_q        <= bri_d;
            frame_tick_q <= frame_tick_d;
            dig_q        <= dig_d;
            y_q          <= y_d;
        end
    end

    // Handshake: a word moves when upd_valid and upd_ready are both high at a rising
    // edge; upd_ready is high exactly while the shadow buffer is empty.
    assign upd_ready  = !pend_valid_q;
    assign frame_tick = frame_tick_q;
    assign DIG        = dig_q;
    assign Y          = y_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 16 ticks per digit) with a
// cycle-level reference model feeding an expected-output queue.
module tb_seg_scan_ctrl;

    localparam int N    = 4;
    localparam int TPD  = 16;
    localparam int STEP = TPD / 8;

    logic        clk;
    logic        rst_n;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [2:0]  brightness;
    logic        frame_tick;
    logic [3:0]  DIG;
    logic [7:0]  Y;

    int checks = 0;
    int errors = 0;

    // {frame_tick, upd_ready, DIG, Y}
    logic [13:0] exp_q[$];

    seg_scan_ctrl #(
        .NUM_DIGITS      (N),
        .TICKS_PER_DIGIT (TPD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .frame_tick (frame_tick),
        .DIG        (DIG),
        .Y          (Y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0:  return 8'hc0;
            4'd1:  return 8'hf9;
            4'd2:  return 8'ha4;
            4'd3:  return 8'hb0;
            4'd4:  return 8'h99;
            4'd5:  return 8'h92;
            4'd6:  return 8'h82;
            4'd7:  return 8'hf8;
            4'd8:  return 8'h80;
            4'd9:  return 8'h90;
            4'd15: return 8'hff;
            default: return 8'hbf;
        endcase
    endfunction

    // Reference model: advances one cycle per rising edge, pushes what the outputs must show next.
    int          m_tick;
    int          m_slot;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    logic [3:0]  m_act_dp;
    logic [3:0]  m_pend_dp;
    logic        m_pv;
    logic [2:0]  m_bri;

    always @(posedge clk) begin : model
        logic [7:0] y;
        logic [3:0] dig;
        logic [3:0] d;
        logic       ft;
        logic       lit;
        if (!rst_n) begin
            m_tick    = 0;
            m_slot    = 0;
            m_act     = 16'h0;
            m_pend    = 16'h0;
            m_act_dp  = 4'h0;
            m_pend_dp = 4'h0;
            m_pv      = 1'b0;
            m_bri     = 3'd0;
            exp_q.push_back({1'b0, 1'b1, 4'hf, 8'hff});
        end else begin
            ft  = (m_tick == TPD - 1) && (m_slot == N - 1);
            lit = (m_tick >= 1) && (m_tick < (int'(m_bri) + 1) * STEP);
            d   = m_act[4*m_slot +: 4];
            y   = seg_of(d);
            if (m_act_dp[m_slot]) y[7] = 1'b0;
            if (blank_lz && m_slot > 0 && (m_act >> (4 * m_slot)) == 16'h0) y[6:0] = 7'h7f;
            dig = 4'hf;
            if (lit) dig[m_slot] = 1'b0;
            else y = 8'hff;
            if (m_tick == 0) m_bri = brightness;
            if (upd_valid && !m_pv) begin
                m_pend    = bcd_in;
                m_pend_dp = dp_in;
                m_pv      = 1'b1;
            end else if (ft && m_pv) begin
                m_act    = m_pend;
                m_act_dp = m_pend_dp;
                m_pv     = 1'b0;
            end
            if (m_tick == TPD - 1) begin
                m_tick = 0;
                m_slot = (m_slot == N - 1) ? 0 : m_slot + 1;
            end else begin
                m_tick = m_tick + 1;
            end
            exp_q.push_back({ft, !m_pv, dig, y});
        end
    end

    always @(negedge clk) begin : scoreboard
        logic [13:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            assert ({frame_tick, upd_ready, DIG, Y} === e) else begin
                errors++;
                $error("FAIL scoreboard obs=%h exp=%h (ft,rdy,DIG,Y)",
                       {frame_tick, upd_ready, DIG, Y}, e);
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ft(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_tick && cnt < 300);
        if (!frame_tick) chk("frame_tick_timeout", 16'(cnt), 16'd64);
    endtask

    task automatic wait_dig(input int idx, output logic [7:0] y);
        logic [3:0] t;
        int         cnt;
        t      = 4'hf;
        t[idx] = 1'b0;
        cnt    = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (DIG !== t && cnt < 300);
        if (DIG !== t) chk("dig_timeout", 16'(DIG), 16'(t));
        y = Y;
    endtask

    task automatic count_low(input int idx, input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (DIG[idx] === 1'b0) lows++;
        end
    endtask

    initial begin
        int         cnt;
        logic [7:0] y;

        // reset hold
        rst_n      = 1'b0;
        upd_valid  = 1'b0;
        bcd_in     = 16'h0;
        dp_in      = 4'h0;
        blank_lz   = 1'b0;
        brightness = 3'd7;
        cyc(3);
        chk("reset_dig", 16'(DIG), 16'hf);
        chk("reset_y", 16'(Y), 16'hff);
        chk("reset_ready", 16'(upd_ready), 16'h1);
        chk("reset_ft", 16'(frame_tick), 16'h0);
        rst_n = 1'b1;
        wait_ft(cnt);
        chk("first_frame_tick", 16'(cnt), 16'd64);
        wait_ft(cnt);
        chk("frame_period", 16'(cnt), 16'd64);

        // update mid-frame becomes visible only after frame end
        cyc(20);
        bcd_in    = 16'h1234;
        dp_in     = 4'h0;
        upd_valid = 1'b1;
        cyc(1);
        upd_valid = 1'b0;
        chk("ready_after_xfer", 16'(upd_ready), 16'h0);
        wait_ft(cnt);
        chk("ready_after_promote", 16'(upd_ready), 16'h1);
        wait_dig(0, y);
        chk("digit0_1234", 16'(y), 16'h99);
        wait_dig(3, y);
        chk("digit3_1234", 16'(y), 16'hf9);

        // leading-zero blanking with a decimal point on digit 1
        bcd_in    = 16'h0007;
        dp_in     = 4'b0010;
        upd_valid = 1'b1;
        cyc(1);
        upd_valid = 1'b0;
        blank_lz  = 1'b1;
        wait_ft(cnt);
        wait_dig(3, y);
        chk("lz_digit3", 16'(y), 16'hff);
        wait_dig(1, y);
        chk("lz_digit1_dp", 16'(y), 16'h7f);
        wait_dig(0, y);
        chk("lz_digit0", 16'(y), 16'hf8);
        blank_lz = 1'b0;
        wait_dig(2, y);
        chk("nolz_digit2", 16'(y), 16'hc0);

        // brightness extremes and a mid-slot change
        brightness = 3'd0;
        wait_ft(cnt);
        count_low(1, 64, cnt);
        chk("bri0_on_cycles", 16'(cnt), 16'd1);
        brightness = 3'd7;
        wait_ft(cnt);
        count_low(1, 64, cnt);
        chk("bri7_on_cycles", 16'(cnt), 16'd15);
        cyc(5);
        brightness = 3'd3;
        count_low(1, 40, cnt);
        chk("bri3_next_slot", 16'(cnt), 16'd7);

        // second offer while pending must wait for upd_ready
        bcd_in    = 16'h0042;
        dp_in     = 4'h0;
        upd_valid = 1'b1;
        cyc(1);
        bcd_in = 16'h5678;
        chk("busy_ready", 16'(upd_ready), 16'h0);
        cnt = 0;
        while (upd_ready !== 1'b1 && cnt < 300) begin
            cyc(1);
            cnt++;
        end
        chk("ready_returns", 16'(upd_ready), 16'h1);
        cyc(1);
        upd_valid = 1'b0;
        chk("held_offer_taken", 16'(upd_ready), 16'h0);
        wait_ft(cnt);
        wait_dig(0, y);
        chk("digit0_5678", 16'(y), 16'h80);

        // offer landing on the frame-end cycle shows one frame later
        wait_ft(cnt);
        cyc(63);
        bcd_in    = 16'h0009;
        upd_valid = 1'b1;
        cyc(1);
        upd_valid = 1'b0;
        chk("fe_offer_ft", 16'(frame_tick), 16'h1);
        chk("fe_offer_captured", 16'(upd_ready), 16'h0);
        wait_dig(0, y);
        chk("fe_offer_not_yet", 16'(y), 16'h80);
        wait_ft(cnt);
        wait_dig(0, y);
        chk("fe_offer_shown", 16'(y), 16'h90);

        // reset mid-slot drops pending data
        cyc(10);
        bcd_in    = 16'h4321;
        upd_valid = 1'b1;
        cyc(1);
        upd_valid = 1'b0;
        cyc(3);
        rst_n = 1'b0;
        cyc(1);
        chk("midreset_dig", 16'(DIG), 16'hf);
        chk("midreset_y", 16'(Y), 16'hff);
        chk("midreset_ready", 16'(upd_ready), 16'h1);
        rst_n = 1'b1;
        wait_ft(cnt);
        chk("midreset_frame", 16'(cnt), 16'd64);
        wait_dig(0, y);
        chk("midreset_zero_shown", 16'(y), 16'hc0);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
